// File: rtl/spi_regbank.sv
// spi_regbank: control/status register bank with sticky event flags and a masked interrupt.
// Define REGBANK_SHADOW_EN to stage control writes in shadow registers that commit on a write to 0x7E.
module spi_regbank #(
  parameter int              DW        = 32,
  parameter int              NUM_CTRL  = 8,
  parameter int              NUM_STAT  = 4,
  parameter logic [DW-1:0]   ID_VALUE  = 32'h1CE40001,
  parameter logic [DW-1:0]   BAD_VALUE = 32'hDEADC0DE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [6:0]               addr,
  input  logic [DW-1:0]            wdat,
  output logic [DW-1:0]            rdat,
  output logic [NUM_CTRL*DW-1:0]   ctrl_q,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [NUM_STAT*DW-1:0]   stat_in,
  input  logic [DW-1:0]            evt_in,
  output logic                     irq
);

  localparam logic [6:0] ADDR_FLAGS  = 7'h7C;
  localparam logic [6:0] ADDR_MASK   = 7'h7D;
  localparam logic [6:0] ADDR_COMMIT = 7'h7E;
  localparam logic [6:0] ADDR_ID     = 7'h7F;
  localparam int         STAT_BASE   = 64;

  logic                   is_ctrl;
  logic                   is_stat;
  logic                   wr_ctrl;
  logic                   wr_flags;
  logic                   wr_mask;
  logic [DW-1:0]          flags_q;
  logic [DW-1:0]          mask_q;
  logic [DW-1:0]          evt_q;
  logic                   evt_armed_q;
  logic [NUM_STAT*DW-1:0] stat_q;
  logic [NUM_CTRL*DW-1:0] ctrl_view;

  always_comb begin
    is_ctrl  = int'(addr) < NUM_CTRL;
    is_stat  = (int'(addr) >= STAT_BASE) && (int'(addr) < STAT_BASE + NUM_STAT);
    wr_ctrl  = we && is_ctrl;
    wr_flags = we && (addr == ADDR_FLAGS);
    wr_mask  = we && (addr == ADDR_MASK);
  end

`ifdef REGBANK_SHADOW_EN
  logic [NUM_CTRL*DW-1:0] shadow_q;
  logic [NUM_CTRL-1:0]    dirty_q;
  logic                   wr_commit;

  assign wr_commit = we && (addr == ADDR_COMMIT);

  // Writes land in the shadow copy; a commit publishes only the dirty entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      shadow_q      <= '0;
      dirty_q       <= '0;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      if (wr_commit) begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (dirty_q[i]) ctrl_q[i*DW +: DW] <= shadow_q[i*DW +: DW];
        end
        ctrl_wr_pulse <= dirty_q;
        dirty_q       <= '0;
      end else begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (wr_ctrl && int'(addr) == i) begin
            shadow_q[i*DW +: DW] <= wdat;
            dirty_q[i]           <= 1'b1;
          end
        end
      end
    end
  end

  assign ctrl_view = shadow_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_ctrl && int'(addr) == i) begin
          ctrl_q[i*DW +: DW] <= wdat;
          ctrl_wr_pulse[i]   <= 1'b1;
        end
      end
    end
  end

  assign ctrl_view = ctrl_q;
`endif

  // evt_armed_q blocks edge detection until evt_q holds a real post-reset sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q       <= '0;
      evt_armed_q <= 1'b0;
      flags_q     <= '0;
      mask_q      <= '0;
      stat_q      <= '0;
      irq         <= 1'b0;
    end else begin
      evt_q       <= evt_in;
      evt_armed_q <= 1'b1;
      flags_q     <= (flags_q & ~(wr_flags ? wdat : '0))
                   | (evt_armed_q ? (evt_in & ~evt_q) : '0);
      if (wr_mask) mask_q <= wdat;
      stat_q      <= stat_in;
      irq         <= |(flags_q & mask_q);
    end
  end

  always_comb begin
    rdat = BAD_VALUE;
    if (is_ctrl) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (int'(addr) == i) rdat = ctrl_view[i*DW +: DW];
      end
    end else if (is_stat) begin
      for (int i = 0; i < NUM_STAT; i++) begin
        if (int'(addr) == STAT_BASE + i) rdat = stat_q[i*DW +: DW];
      end
    end else begin
      case (addr)
        ADDR_FLAGS:  rdat = flags_q;
        ADDR_MASK:   rdat = mask_q;
        ADDR_COMMIT: rdat = '0;
        ADDR_ID:     rdat = ID_VALUE;
        default:     rdat = BAD_VALUE;
      endcase
    end
  end

endmodule
